fb_scheduler: RTL
=================

// Module: fb_scheduler
// PURPOSE
//  Frame-buffer scheduler for the VDMA path. Owns C_BUF_NUM frame buffers in DDR and
//  hands buffer addresses to one writer (s2mm, w_sof/w_addr) and one reader
//  (mm2s, r_sof/r_addr). The writer never targets the buffer being read. The reader
//  always takes the newest completed frame, repeating a frame when none is new.
//  Drop and repeat statistics go to the register bank.
// PARAMETERS
//  C_BUF_NUM           3   number of frame buffers; legal 3..4
//  C_M_AXI_ADDR_WIDTH  32  address width of buf_base/buf_stride/w_addr/r_addr
//  C_CNT_WIDTH         16  width of drop/repeat counters
// PORTS
//  aclk        in   1     clock; all logic on rising edge
//  reset       in   1     synchronous, active-high; clears everything
//  soft_reset  in   1     sync, active-high; re-inits scheduling state, counters kept
//  buf_base    in   AW    address of buffer 0 (static config)
//  buf_stride  in   AW    byte distance between consecutive buffers (static config)
//  w_sof       in   1     1-cycle pulse: writer starts a new frame
//  w_idx       out  2     buffer index writer must use
//  w_addr      out  AW    buf_base + w_idx*buf_stride
//  r_sof       in   1     1-cycle pulse: reader starts a new frame
//  r_idx       out  2     buffer index reader must use
//  r_addr      out  AW    buf_base + r_idx*buf_stride
//  frame_avail out  1     at least one frame completed since (soft) reset
//  drop_cnt    out  CW    completed frames overwritten before being read, saturating
//  repeat_cnt  out  CW    r_sof with no new frame, saturating
// BEHAVIOUR
//  Internal state: w_idx, r_idx, last_idx, w_active, fresh, frame_avail.
//  Reset values: w_idx=0, r_idx=1, last_idx=0, w_active=0, fresh=0, frame_avail=0.
//    Counters are 0; w_addr=buf_base; r_addr=buf_base+buf_stride after first clk.
//  soft_reset: same init as reset except drop_cnt/repeat_cnt keep their values.
//    It has priority over w_sof/r_sof in the same cycle.
//  w_sof, w_active=0: set w_active=1; w_idx unchanged; nothing completes.
//  w_sof, w_active=1: the frame in w_idx completes.
//    last_idx'=w_idx; fresh'=1; frame_avail'=1.
//    If fresh was already 1 and r_sof is not asserted the same cycle: drop_cnt+1.
//    New w_idx = lowest index not in {r_idx', last_idx'}; always exists since N>=3.
//  r_sof: if fresh (after same-cycle completion, see below): r_idx'=last_idx, fresh'=0.
//    Else r_idx unchanged, repeat_cnt+1.
//  Simultaneous w_sof+r_sof: completion is applied first.
//    Reader gets the just-completed buffer (old w_idx), no drop is counted.
//    Writer picks the lowest index != old w_idx.
//  Counters saturate at all-ones and never wrap.
//  Latency: w_idx/r_idx update on the edge after the sof pulse.
//    w_addr/r_addr are registered: valid 2 cycles after the pulse.
//    Consumers sample the address no earlier than 2 cycles after their sof.
//  Address arithmetic is modulo 2^AW (wrap ignored). idx*stride is a shift-add; no multiplier.
//  Invariant (assertion): w_idx != r_idx and w_idx != last_idx whenever fresh or frame_avail.
// STRUCTURE
//  Shared package fsref_fb_pkg holds:
//    C_FB_IDX_BITS=2.
//    Function fb_lowest_free(n, a, b): lowest index < n excluding a and b.
//  No sub-module. Single always block for the state, one for the counters,
//  one for the address registers.
// TESTING  (buf_base=32'h1000_0000, buf_stride=32'h0020_0000, C_BUF_NUM=3)
//  1. Reset held 3 clks, release
//     -> w_idx=0, w_addr=32'h1000_0000, r_idx=1, r_addr=32'h1020_0000,
//        frame_avail=0, counters 0.
//  2. w_sof, 10 clks, w_sof
//     -> last_idx=0, w_idx=2, w_addr=32'h1040_0000, frame_avail=1;
//     then r_sof -> r_idx=0, r_addr=32'h1000_0000 two clks later, repeat_cnt=0.
//  3. Following 2, r_sof again with no new w_sof
//     -> r_idx stays 0, repeat_cnt=1.
//  4. From r_idx=0, w_idx=2: w_sof, w_sof, no r_sof
//     -> drop_cnt=1, last_idx=1, w_idx=2; then r_sof -> r_idx=1.
//  5. w_sof and r_sof in same cycle with w_idx=2, r_idx=0
//     -> r_idx=2, w_idx=0, drop_cnt unchanged.
//  6. soft_reset mid-stream with drop_cnt=1, repeat_cnt=1
//     -> state as test 1 but counters stay 1,1; w_sof same cycle ignored.
//  Also: 4 M random sof pulses with the invariant assertion active; force counters near max -> saturate.

Source files
------------

// File: rtl/fb_scheduler_pkg.sv
// Shared frame-buffer definitions: index type and the free-buffer picker that
// both the scheduler and any future buffer consumers can reuse.
package fsref_fb_pkg;

    localparam int C_FB_IDX_BITS = 2;

    typedef logic [C_FB_IDX_BITS-1:0] fb_idx_t;

    // Lowest buffer index below n that is neither a nor b.
    function automatic fb_idx_t fb_lowest_free(input int n, input fb_idx_t a, input fb_idx_t b);
        fb_idx_t res;
        res = '0;
        for (int i = 3; i >= 0; i--) begin
            if (i < n && fb_idx_t'(i) != a && fb_idx_t'(i) != b) begin
                res = fb_idx_t'(i);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/fb_scheduler_if.sv
// Bundle between the frame-buffer scheduler and its writer/reader/config side.
// The master side pulses the sofs and supplies the static buffer layout.
interface fb_scheduler_if #(
    parameter int AW = 32,
    parameter int CW = 16
);
    import fsref_fb_pkg::*;

    logic          soft_reset;
    logic [AW-1:0] buf_base;
    logic [AW-1:0] buf_stride;
    logic          w_sof;
    fb_idx_t       w_idx;
    logic [AW-1:0] w_addr;
    logic          r_sof;
    fb_idx_t       r_idx;
    logic [AW-1:0] r_addr;
    logic          frame_avail;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] repeat_cnt;

    modport master (
        output soft_reset, buf_base, buf_stride, w_sof, r_sof,
        input  w_idx, w_addr, r_idx, r_addr, frame_avail, drop_cnt, repeat_cnt
    );

    modport slave (
        input  soft_reset, buf_base, buf_stride, w_sof, r_sof,
        output w_idx, w_addr, r_idx, r_addr, frame_avail, drop_cnt, repeat_cnt
    );

endinterface

// File: rtl/fb_scheduler.sv
// Frame-buffer scheduler: the writer never lands on the buffer being read, the
// reader always jumps to the newest completed frame, drops/repeats are counted.
module fb_scheduler
    import fsref_fb_pkg::*;
#(
    parameter int C_BUF_NUM          = 3,
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_CNT_WIDTH        = 16
) (
    input  logic          aclk,
    input  logic          reset,
    fb_scheduler_if.slave bus
);

    localparam int AW = C_M_AXI_ADDR_WIDTH;
    localparam int CW = C_CNT_WIDTH;

    fb_idx_t       w_idx_q, r_idx_q, last_q;
    logic          w_active_q, fresh_q, avail_q;
    logic [CW-1:0] drop_q, repeat_q;
    logic [AW-1:0] w_addr_q, r_addr_q;

    logic          complete, fresh_mid, take, drop_inc, repeat_inc, fresh_next;
    fb_idx_t       last_mid, r_next, w_next;

    // idx * stride as a shift-add; idx is at most 3.
    function automatic logic [AW-1:0] idx_offset(input fb_idx_t idx, input logic [AW-1:0] stride);
        logic [AW-1:0] acc;
        acc = '0;
        if (idx[0]) acc = acc + stride;
        if (idx[1]) acc = acc + (stride << 1);
        return acc;
    endfunction

    // Completion is resolved before the reader looks, so a same-cycle r_sof
    // picks up the frame that just finished instead of counting a drop.
    always_comb begin
        // NOTE: every signal gets a value before any condition, so no latch can be inferred.
        complete   = 1'b0;
        fresh_mid  = fresh_q;
        last_mid   = last_q;
        take       = 1'b0;
        r_next     = r_idx_q;
        w_next     = w_idx_q;
        fresh_next = fresh_q;
        drop_inc   = 1'b0;
        repeat_inc = 1'b0;

        complete  = bus.w_sof && w_active_q;
        if (complete) begin
            fresh_mid = 1'b1;
            last_mid  = w_idx_q;
        end
        drop_inc = complete && fresh_q && !bus.r_sof;

        take       = bus.r_sof && fresh_mid;
        repeat_inc = bus.r_sof && !fresh_mid;
        if (take) begin
            r_next = last_mid;
        end
        fresh_next = fresh_mid && !bus.r_sof;

        if (complete) begin
            w_next = fb_lowest_free(C_BUF_NUM, r_next, last_mid);
        end
    end

    always_ff @(posedge aclk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset || bus.soft_reset) begin
            w_idx_q    <= fb_idx_t'(0);
            r_idx_q    <= fb_idx_t'(1);
            last_q     <= fb_idx_t'(0);
            w_active_q <= 1'b0;
            fresh_q    <= 1'b0;
            avail_q    <= 1'b0;
        end else begin
            if (bus.w_sof) w_active_q <= 1'b1;
            if (complete)  avail_q    <= 1'b1;
            w_idx_q <= w_next;
            r_idx_q <= r_next;
            last_q  <= last_mid;
            fresh_q <= fresh_next;
        end
    end

    // Statistics survive soft_reset; both saturate at all-ones.
    always_ff @(posedge aclk) begin
        if (reset) begin
            drop_q   <= '0;
            repeat_q <= '0;
        end else if (!bus.soft_reset) begin
            if (drop_inc && drop_q != '1)     drop_q   <= drop_q + CW'(1);
            if (repeat_inc && repeat_q != '1) repeat_q <= repeat_q + CW'(1);
        end
    end

    always_ff @(posedge aclk) begin
        if (reset) begin
            w_addr_q <= bus.buf_base;
            r_addr_q <= bus.buf_base + bus.buf_stride;
        end else begin
            w_addr_q <= bus.buf_base + idx_offset(w_idx_q, bus.buf_stride);
            r_addr_q <= bus.buf_base + idx_offset(r_idx_q, bus.buf_stride);
        end
    end

    assign bus.w_idx       = w_idx_q;
    assign bus.r_idx       = r_idx_q;
    assign bus.w_addr      = w_addr_q;
    assign bus.r_addr      = r_addr_q;
    assign bus.frame_avail = avail_q;
    assign bus.drop_cnt    = drop_q;
    assign bus.repeat_cnt  = repeat_q;

    a_no_collide: assert property (@(posedge aclk) disable iff (reset)
        (fresh_q || avail_q) |-> (w_idx_q != r_idx_q && w_idx_q != last_q));

endmodule
